// File: rtl/button_event_scheduler.sv
// Multi-button debouncer with a shared prescaler and a one-button-per-cycle scanner.
// Debounced edges become events, handed out round-robin. `AUTOREPEAT_EN adds held-key repeat.
module button_event_scheduler #(
  parameter int NUM_BTN      = 4,
  parameter int IDX_W        = 2,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int CNT_W        = 4
`ifdef AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 300,
  parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] raw,
  output logic [NUM_BTN-1:0] level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDX_W-1:0]   evt_idx,
  output logic               evt_press,
  output logic               overrun
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] STABLE_VAL = CNT_W'(STABLE_TICKS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BTN - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  logic [NUM_BTN-1:0] sync1_reg, sync2_reg;
  logic [PW-1:0]      presc_reg;
  logic               tick;
  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   scan_idx_reg, scan_idx_next;

  logic [CNT_W-1:0]   cnt_reg  [NUM_BTN];
  logic [CNT_W-1:0]   cnt_next [NUM_BTN];
  logic [NUM_BTN-1:0] level_reg;
  logic [NUM_BTN-1:0] pending_reg, pdir_reg;
  logic [NUM_BTN-1:0] proc, flip, rpt_hit, pend_set, grant_clr;
  logic               overrun_reg;

  logic               evt_valid_reg, evt_press_reg;
  logic [IDX_W-1:0]   evt_idx_reg, ptr_reg;
  logic               load, found;
  logic [IDX_W-1:0]   sel_idx, cand_idx;

  assign tick = (presc_reg == TICK_LAST);

  always_comb begin
    state_next    = state_reg;
    scan_idx_next = scan_idx_reg;
    case (state_reg)
      S_IDLE: if (tick) begin
        state_next    = S_SCAN;
        scan_idx_next = '0;
      end
      S_SCAN: if (scan_idx_reg == LAST_IDX) begin
        state_next    = S_IDLE;
        scan_idx_next = '0;
      end else begin
        scan_idx_next = scan_idx_reg + 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0]      rpt_cnt_reg  [NUM_BTN];
  logic [RW-1:0]      rpt_cnt_next [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_armed_reg, rpt_armed_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic differ;
      assign proc[gi]  = (state_reg == S_SCAN) && (scan_idx_reg == IDX_W'(gi));
      assign differ    = sync2_reg[gi] != level_reg[gi];
      assign flip[gi]  = proc[gi] && differ && ((cnt_reg[gi] + CNT_W'(1)) == STABLE_VAL);
      assign cnt_next[gi] = !proc[gi]            ? cnt_reg[gi] :
                            (!differ || flip[gi]) ? '0 : cnt_reg[gi] + CNT_W'(1);
      assign grant_clr[gi] = load && (sel_idx == IDX_W'(gi));
      assign pend_set[gi]  = flip[gi] || rpt_hit[gi];
`ifdef AUTOREPEAT_EN
      logic [RW-1:0] target;
      assign target = rpt_armed_reg[gi] ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
      assign rpt_hit[gi] = proc[gi] && level_reg[gi] && !flip[gi] &&
                           ((rpt_cnt_reg[gi] + RW'(1)) == target);
      // Any release (or a flip, which from level 1 is a release) restarts the delay.
      always_comb begin
        rpt_cnt_next[gi]   = rpt_cnt_reg[gi];
        rpt_armed_next[gi] = rpt_armed_reg[gi];
        if (!level_reg[gi] || flip[gi]) begin
          rpt_cnt_next[gi]   = '0;
          rpt_armed_next[gi] = 1'b0;
        end else if (rpt_hit[gi]) begin
          rpt_cnt_next[gi]   = '0;
          rpt_armed_next[gi] = 1'b1;
        end else if (proc[gi]) begin
          rpt_cnt_next[gi] = rpt_cnt_reg[gi] + RW'(1);
        end
      end
`else
      assign rpt_hit[gi] = 1'b0;
`endif
    end
  endgenerate

  // First pending index strictly after the last grant, wrapping around.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      cand_idx = IDX_W'((int'(ptr_reg) + k) % NUM_BTN);
      if (!found && pending_reg[cand_idx]) begin
        found   = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  assign load = (!evt_valid_reg || evt_ready) && (|pending_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      presc_reg     <= '0;
      state_reg     <= S_IDLE;
      scan_idx_reg  <= '0;
      level_reg     <= '0;
      pending_reg   <= '0;
      pdir_reg      <= '0;
      overrun_reg   <= 1'b0;
      evt_valid_reg <= 1'b0;
      evt_idx_reg   <= '0;
      evt_press_reg <= 1'b0;
      ptr_reg       <= LAST_IDX;
      for (int i = 0; i < NUM_BTN; i++) cnt_reg[i] <= '0;
`ifdef AUTOREPEAT_EN
      rpt_armed_reg <= '0;
      for (int i = 0; i < NUM_BTN; i++) rpt_cnt_reg[i] <= '0;
`endif
    end else begin
      sync1_reg    <= raw;
      sync2_reg    <= sync1_reg;
      presc_reg    <= tick ? '0 : presc_reg + 1'b1;
      state_reg    <= state_next;
      scan_idx_reg <= scan_idx_next;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_reg[i] <= cnt_next[i];
        if (flip[i]) level_reg[i] <= sync2_reg[i];
        if (pend_set[i]) pdir_reg[i] <= flip[i] ? sync2_reg[i] : 1'b1;
      end
`ifdef AUTOREPEAT_EN
      rpt_armed_reg <= rpt_armed_next;
      for (int i = 0; i < NUM_BTN; i++) rpt_cnt_reg[i] <= rpt_cnt_next[i];
`endif
      // A new set beats a same-cycle grant; the granted copy already sits in the output register.
      pending_reg <= pend_set | (pending_reg & ~grant_clr);
      overrun_reg <= |(flip & pending_reg & ~grant_clr);
      if (load) begin
        evt_valid_reg <= 1'b1;
        evt_idx_reg   <= sel_idx;
        evt_press_reg <= pdir_reg[sel_idx];
        ptr_reg       <= sel_idx;
      end else if (evt_valid_reg && evt_ready) begin
        evt_valid_reg <= 1'b0;
      end
    end
  end

  assign level     = level_reg;
  assign evt_valid = evt_valid_reg;
  assign evt_idx   = evt_idx_reg;
  assign evt_press = evt_press_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with a short prescaler (TICK_DIV=8, STABLE_TICKS=3).
module tb_button_event_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] raw = 4'b0000;
  logic [3:0] level;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [1:0] evt_idx;
  logic       evt_press;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ovr_cnt = 0;

  typedef struct {int idx; int press; int cyc;} ev_t;
  ev_t evq[$];

  always #5 clk = ~clk;

  button_event_scheduler #(
    .NUM_BTN(4), .IDX_W(2), .TICK_DIV(8), .STABLE_TICKS(3), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raw(raw), .level(level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_press(evt_press), .overrun(overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes and overrun pulses are logged mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (evt_valid && evt_ready) evq.push_back('{int'(evt_idx), int'(evt_press), cyc});
      if (overrun) ovr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int q_idx(input int n);
    return (n < evq.size()) ? evq[n].idx : -1;
  endfunction
  function automatic int q_press(input int n);
    return (n < evq.size()) ? evq[n].press : -1;
  endfunction
  function automatic int q_cyc(input int n);
    return (n < evq.size()) ? evq[n].cyc : -1;
  endfunction

  initial begin
    int bad;
    step(3);
    check("rst_level", 32'(level), 32'h0);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_idx", 32'(evt_idx), 32'h0);
    check("rst_press", 32'(evt_press), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    step(2);

    // single press/release of button 1
    raw = 4'b0010;
    step(16);
    check("t1_level_early", 32'(level), 32'h0);
    step(24);
    check("t1_level_set", 32'(level), 32'h2);
    step(4);
    check("t1_nevents", 32'(evq.size()), 32'd1);
    check("t1_idx", 32'(q_idx(0)), 32'd1);
    check("t1_press", 32'(q_press(0)), 32'd1);
    raw = 4'b0000;
    step(44);
    check("t1_rel_level", 32'(level), 32'h0);
    check("t1_rel_n", 32'(evq.size()), 32'd2);
    check("t1_rel_press", 32'(q_press(1)), 32'd0);
    evq.delete();

    // bounce on button 2 must not flip or leave a stale count
    raw = 4'b0100;
    step(14);
    raw = 4'b0000;
    step(40);
    check("t2_bounce_level", 32'(level), 32'h0);
    check("t2_bounce_nev", 32'(evq.size()), 32'd0);
    raw = 4'b0100;
    step(16);
    check("t2_fresh_early", 32'(level), 32'h0);
    step(24);
    check("t2_fresh_level", 32'(level), 32'h4);
    raw = 4'b0000;
    step(44);
    check("t2_nev", 32'(evq.size()), 32'd2);
    check("t2_ev0", 32'(q_idx(0) * 2 + q_press(0)), 32'd5);
    evq.delete();

    // simultaneous presses on 0 and 2 with back-pressure
    evt_ready = 1'b0;
    raw = 4'b0101;
    step(44);
    check("t3_valid", 32'(evt_valid), 32'd1);
    check("t3_idx", 32'(evt_idx), 32'd0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (!(evt_valid === 1'b1 && evt_idx === 2'd0 && evt_press === 1'b1)) bad++;
    end
    check("t3_hold_stable", 32'(bad), 32'd0);
    evt_ready = 1'b1;
    step(4);
    check("t3_nev", 32'(evq.size()), 32'd2);
    check("t3_first", 32'(q_idx(0)), 32'd0);
    check("t3_second", 32'(q_idx(1)), 32'd2);
    check("t3_b2b", 32'(q_cyc(1) - q_cyc(0)), 32'd1);
    raw = 4'b0000;
    step(44);
    check("t3_rel_nev", 32'(evq.size()), 32'd4);
    evq.delete();

    // button 3 press+release pile up behind a held event from button 1
    evt_ready = 1'b0;
    raw = 4'b0010;
    step(44);
    check("t4_held_valid", 32'(evt_valid), 32'd1);
    raw = 4'b1010;
    step(44);
    check("t4_level_press", 32'(level), 32'ha);
    check("t4_no_ovr_yet", 32'(ovr_cnt), 32'd0);
    raw = 4'b0010;
    step(44);
    check("t4_level_rel", 32'(level), 32'h2);
    check("t4_ovr_once", 32'(ovr_cnt), 32'd1);
    evt_ready = 1'b1;
    step(4);
    check("t4_nev", 32'(evq.size()), 32'd2);
    check("t4_ev0", 32'(q_idx(0) * 2 + q_press(0)), 32'd3);
    check("t4_ev1", 32'(q_idx(1) * 2 + q_press(1)), 32'd6);
    raw = 4'b0000;
    step(44);
    evq.delete();

    // round-robin: with 0 just granted, pending 1 must beat pending 0
    evt_ready = 1'b0;
    raw = 4'b0001;
    step(44);
    raw = 4'b0011;
    step(44);
    raw = 4'b0010;
    step(44);
    evt_ready = 1'b1;
    step(4);
    check("t5_nev", 32'(evq.size()), 32'd3);
    check("t5_ev0", 32'(q_idx(0) * 2 + q_press(0)), 32'd1);
    check("t5_ev1", 32'(q_idx(1) * 2 + q_press(1)), 32'd3);
    check("t5_ev2", 32'(q_idx(2) * 2 + q_press(2)), 32'd0);
    raw = 4'b0000;
    step(44);
    check("t5_ev3", 32'(q_idx(3) * 2 + q_press(3)), 32'd2);
    check("t5_ovr_total", 32'(ovr_cnt), 32'd1);
    evq.delete();

    // asynchronous reset while an event is held
    evt_ready = 1'b0;
    raw = 4'b0100;
    step(44);
    check("t6_pre_valid", 32'(evt_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(evt_valid), 32'd0);
    check("t6_async_level", 32'(level), 32'h0);
    check("t6_async_ovr", 32'(overrun), 32'd0);
    step(3);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    step(44);
    check("t6_post_level", 32'(level), 32'h4);
    check("t6_post_nev", 32'(evq.size()), 32'd1);
    check("t6_post_ev", 32'(q_idx(0) * 2 + q_press(0)), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
